// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Holds the arbiter FSM state encoding and the default fairness/timeout limits.
// No logic; imported by riscv_mem_arb.
package riscv_mem_pkg;

  // One memory transaction outstanding at a time; the BUSY state names the owner.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  // Consecutive data grants tolerated while a fetch is waiting.
  localparam int unsigned STARVE_MAX_DEF = 4;
  // Busy cycles without m_ack before the transaction is abandoned.
  localparam int unsigned TIMEOUT_DEF    = 16;

endpackage

// File: rtl/riscv_mem_arb.sv
// Arbitrates fetch (i_*) and data (d_*) requesters onto one memory port (m_*).
// Latency: grant on the IDLE cycle's edge, done is m_ack passed through (>= 1 cycle).
// Backpressure: requesters hold req until done; StallF/StallM stall the pipeline meanwhile.
//
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   i_req/i_addr          fetch request, i_done/i_rdata completion
//   d_req/d_we/d_addr/d_wdata  data request, d_done/d_rdata completion
//   m_req/m_we/m_addr/m_wdata  memory command, m_ack/m_rdata memory response
//   StallF, StallM        pipeline stalls; err flags a timed-out access
module riscv_mem_arb
  import riscv_mem_pkg::*;
#(
  parameter int unsigned Width      = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req,
  input  logic [Width-1:0] i_addr,
  output logic             i_done,
  output logic [Width-1:0] i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [Width-1:0] d_addr,
  input  logic [Width-1:0] d_wdata,
  output logic             d_done,
  output logic [Width-1:0] d_rdata,
  output logic             m_req,
  output logic             m_we,
  output logic [Width-1:0] m_addr,
  output logic [Width-1:0] m_wdata,
  input  logic             m_ack,
  input  logic [Width-1:0] m_rdata,
  output logic             StallF,
  output logic             StallM,
  output logic             err
);

  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  arb_state_e       state_q, state_d;
  logic [SCW-1:0]   starve_q, starve_d;
  logic [TCW-1:0]   tmo_q, tmo_d;
  logic             m_we_q, m_we_d;
  logic [Width-1:0] m_addr_q, m_addr_d;
  logic [Width-1:0] m_wdata_q, m_wdata_d;

  logic starve_full;
  logic fetch_due;
  logic tmo_hit;

  assign starve_full = (starve_q == SCW'(STARVE_MAX));
  // A waiting fetch that has already been passed over STARVE_MAX times wins.
  assign fetch_due   = i_req && starve_full;
  assign tmo_hit     = (tmo_q == TCW'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      tmo_q     <= '0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      tmo_q     <= tmo_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    tmo_d     = tmo_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_done    = 1'b0;
    d_done    = 1'b0;
    err       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // m_ack is ignored here; the busy counter restarts for the next access.
        tmo_d = '0;
        if (d_req && !fetch_due) begin
          state_d   = BUSY_D;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          if (i_req && !starve_full) begin
            starve_d = starve_q + SCW'(1);
          end
        end else if (i_req) begin
          state_d   = BUSY_I;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
          starve_d  = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        // An ack in the timeout cycle still counts as a clean completion.
        if (m_ack || tmo_hit) begin
          state_d = IDLE;
          err     = ~m_ack;
          if (state_q == BUSY_I) begin
            i_done = 1'b1;
          end else begin
            d_done = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + TCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_req   = (state_q != IDLE);
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

  assign i_rdata = i_done ? m_rdata : '0;
  assign d_rdata = d_done ? m_rdata : '0;

  assign StallF  = i_req & ~i_done;
  assign StallM  = d_req & ~d_done;

endmodule

// File: tb/tb_riscv_mem_arb.sv
module tb_riscv_mem_arb;

  localparam int SMAX = 4;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, m_ack;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic        i_done, d_done, m_req, m_we, StallF, StallM, err;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_mem_arb #(.Width(32), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .StallF(StallF), .StallM(StallM), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction starting from an IDLE cycle with requests already driven.
  task automatic xact(input bit is_d, input logic [31:0] addr, input bit we,
                      input logic [31:0] wd, input int lat, input logic [31:0] rd,
                      input string tag);
    step();
    chk({tag, ".m_req"}, {31'd0, m_req}, 32'd1);
    chk({tag, ".m_addr"}, m_addr, addr);
    chk({tag, ".m_we"}, {31'd0, m_we}, {31'd0, we});
    if (we) chk({tag, ".m_wdata"}, m_wdata, wd);
    for (int k = 0; k < lat; k++) begin
      chk({tag, ".wait_done"}, {30'd0, i_done, d_done}, 32'd0);
      chk({tag, ".wait_stall"}, {30'd0, StallF, StallM}, {30'd0, i_req, d_req});
      step();
      chk({tag, ".hold_m_req"}, {31'd0, m_req}, 32'd1);
      if (we) chk({tag, ".hold_m_wdata"}, m_wdata, wd);
    end
    m_ack = 1'b1;
    m_rdata = rd;
    #1;
    chk({tag, ".done"}, {30'd0, i_done, d_done}, is_d ? 32'd1 : 32'd2);
    chk({tag, ".rdata"}, is_d ? d_rdata : i_rdata, rd);
    chk({tag, ".other_rdata"}, is_d ? i_rdata : d_rdata, 32'd0);
    chk({tag, ".err"}, {31'd0, err}, 32'd0);
    chk({tag, ".stall_release"}, {31'd0, is_d ? StallM : StallF}, 32'd0);
    step();
    m_ack = 1'b0;
    m_rdata = '0;
    chk({tag, ".idle_m_req"}, {31'd0, m_req}, 32'd0);
  endtask

  // Timeout run for a data request; ack_last drives m_ack in the timeout cycle.
  task automatic timeout_run(input bit ack_last, input string tag);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    step();
    chk({tag, ".m_req_rise"}, {31'd0, m_req}, 32'd1);
    for (int k = 1; k < TMO; k++) begin
      step();
      chk({tag, ".no_done"}, {30'd0, d_done, err}, 32'd0);
      chk({tag, ".m_req_hold"}, {31'd0, m_req}, 32'd1);
    end
    step();
    if (ack_last) begin
      m_ack = 1'b1; m_rdata = 32'hA5A5_0001;
    end
    #1;
    chk({tag, ".done_pulse"}, {31'd0, d_done}, 32'd1);
    chk({tag, ".err"}, {31'd0, err}, {31'd0, ~ack_last});
    step();
    m_ack = 1'b0; m_rdata = '0; d_req = 1'b0;
    chk({tag, ".after"}, {29'd0, m_req, d_done, err}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int     starve_m;
    bit     ip, dp, dwe, win_d;
    logic [31:0] ia, da, dw;

    reset = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; m_ack = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
    #12;
    chk("reset.m_bus", {29'd0, m_req, m_we, err}, 32'd0);
    chk("reset.m_addr", m_addr, 32'd0);
    chk("reset.m_wdata", m_wdata, 32'd0);
    chk("reset.done", {30'd0, i_done, d_done}, 32'd0);
    chk("reset.stall", {30'd0, StallF, StallM}, 32'd0);
    reset = 1'b1;
    step();

    // m_ack in IDLE must be ignored
    m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF; #1;
    chk("idle_ack.done", {29'd0, i_done, d_done, err}, 32'd0);
    chk("idle_ack.rdata", d_rdata | i_rdata, 32'd0);
    step();
    m_ack = 1'b0; m_rdata = '0;

    // single read, ack one cycle after m_req
    d_req = 1; d_we = 0; d_addr = 32'h40;
    xact(1'b1, 32'h40, 1'b0, 32'd0, 1, 32'hDEADBEEF, "read");
    d_req = 0; #1;
    chk("read.stallm_after", {31'd0, StallM}, 32'd0);

    // write
    d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h12345678;
    xact(1'b1, 32'h80, 1'b1, 32'h12345678, 3, 32'h0, "write");
    d_req = 0; d_we = 0;

    // collision: data first, then fetch after one IDLE cycle
    i_req = 1; i_addr = 32'h100; d_req = 1; d_addr = 32'h40;
    xact(1'b1, 32'h40, 1'b0, 32'd0, 0, 32'h1111_2222, "coll.d");
    d_req = 0;
    xact(1'b0, 32'h100, 1'b0, 32'd0, 0, 32'h3333_4444, "coll.i");
    i_req = 0;

    // starvation: four data grants, then the fetch, then the counter restarts
    i_req = 1; i_addr = 32'h200; d_req = 1; d_addr = 32'h300;
    for (int n = 0; n < SMAX; n++) xact(1'b1, 32'h300, 1'b0, 32'd0, 0, 32'h10 + n, "starve.d");
    xact(1'b0, 32'h200, 1'b0, 32'd0, 0, 32'h2222, "starve.i");
    for (int n = 0; n < SMAX; n++) xact(1'b1, 32'h300, 1'b0, 32'd0, 1, 32'h20 + n, "restart.d");
    xact(1'b0, 32'h200, 1'b0, 32'd0, 0, 32'h2223, "restart.i");
    i_req = 0; d_req = 0;

    timeout_run(1'b0, "timeout");
    timeout_run(1'b1, "late_ack");

    // reset in the middle of a fetch
    i_req = 1; i_addr = 32'h600;
    step();
    chk("rst_mid.busy", {31'd0, m_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid.m_req", {31'd0, m_req}, 32'd0);
    chk("rst_mid.m_addr", m_addr, 32'd0);
    chk("rst_mid.done", {30'd0, i_done, d_done}, 32'd0);
    step();
    i_req = 0; m_ack = 1; reset = 1'b1;
    step();
    chk("rst_rel.done", {29'd0, i_done, d_done, err}, 32'd0);
    chk("rst_rel.m_req", {31'd0, m_req}, 32'd0);
    m_ack = 0;

    // randomized traffic against a transaction-level arbitration model
    starve_m = 0; ip = 0; dp = 0; dwe = 0; ia = '0; da = '0; dw = '0;
    for (int t = 0; t < 40; t++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1; ia = $urandom;
      end
      if (!dp && ($urandom_range(0, 1) == 1 || !ip)) begin
        dp = 1; da = $urandom; dw = $urandom; dwe = 1'($urandom_range(0, 1));
      end
      i_req = ip; i_addr = ia;
      d_req = dp; d_addr = da; d_wdata = dw; d_we = dwe;
      win_d = dp && !(ip && starve_m == SMAX);
      if (win_d) begin
        xact(1'b1, da, dwe, dw, $urandom_range(0, 4), $urandom, "rand.d");
        if (ip && starve_m < SMAX) starve_m++;
        dp = 0; d_req = 0;
      end else begin
        xact(1'b0, ia, 1'b0, 32'd0, $urandom_range(0, 4), $urandom, "rand.i");
        starve_m = 0;
        ip = 0; i_req = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
